crm_store: RTL

Parametrised CRAM control store with a word-assembling loader port, stored parity and selectable read latency. It generalises the fixed 2K×84 read-only microcode store: depth, width, load chunk width and read latency are parameters. Diagnostic/console logic loads microwords in chunks while the EBOX is stopped; the EBOX reads one word per cycle by CRADR. Field decoding of the output word stays outside this block.

---
 rtl/crm_store_if.sv | 31 +++
 rtl/crm_store.sv | 151 +++++++++++++++
 2 files changed

// File: rtl/crm_store_if.sv
// Bus bundle for the control store: EBOX read side, error reporting and the
// chunked loader handshake. Words and chunks use bit 0 as the MSB.
interface crm_store_if #(
    parameter int ADDRW = 11,
    parameter int WIDTH = 84,
    parameter int LDW   = 36
);
    logic             run;
    logic [ADDRW-1:0] cradr;
    logic [0:WIDTH-1] cram_data;
    logic             cram_perr;
    logic             perr_sticky;
    logic             perr_clr;
    logic [ADDRW-1:0] ld_addr;
    logic             ld_addr_we;
    logic [0:LDW-1]   ld_data;
    logic             ld_badpar;
    logic             ld_valid;
    logic             ld_ready;
    logic             ld_done;

    modport master (
        output run, cradr, perr_clr, ld_addr, ld_addr_we, ld_data, ld_badpar, ld_valid,
        input  cram_data, cram_perr, perr_sticky, ld_ready, ld_done
    );

    modport slave (
        input  run, cradr, perr_clr, ld_addr, ld_addr_we, ld_data, ld_badpar, ld_valid,
        output cram_data, cram_perr, perr_sticky, ld_ready, ld_done
    );
endinterface

// File: rtl/crm_store.sv
// Microcode control store: parity-protected RAM filled chunk by chunk from the
// console loader, read every cycle through an address register by the EBOX.
module crm_store #(
    parameter int DEPTH    = 2048,
    parameter int WIDTH    = 84,
    parameter int LDW      = 36,
    parameter int READ_LAT = 1,
    parameter int AUTOINC  = 1
) (
    input  logic        clk,
    input  logic        reset,
    crm_store_if.slave  bus
);
    localparam int ADDRW  = $clog2(DEPTH);
    localparam int NCHUNK = (WIDTH + LDW - 1) / LDW;
    localparam int KW     = $clog2(NCHUNK);

    typedef enum logic {COLLECT, WRITE} state_t;

    state_t           state_reg;
    logic [KW-1:0]    k_reg;
    logic [ADDRW-1:0] ptr_reg;
    logic [ADDRW-1:0] ptr_next;
    logic [0:WIDTH-1] word_reg;
    logic [0:WIDTH-1] word_next;
    logic             badpar_reg;
    logic             done_reg;
    logic             sticky_reg;
    logic             accept;
    logic             last_chunk;
    logic             we;
    logic [0:WIDTH]   wr_word;
    logic [0:WIDTH]   mem [DEPTH];
    logic [ADDRW-1:0] cradr_reg;
    logic [0:WIDTH]   rd_reg;
    logic             perr_now;
    logic             unused_ld_tail;

    assign bus.ld_ready = !bus.run && (state_reg == COLLECT) && !bus.ld_addr_we;
    assign bus.ld_done  = done_reg;
    assign accept       = bus.ld_valid && bus.ld_ready;
    assign last_chunk   = (k_reg == KW'(NCHUNK - 1));
    assign ptr_next     = (ptr_reg == ADDRW'(DEPTH - 1)) ? '0 : ptr_reg + ADDRW'(1);
    // Bits of the final chunk beyond the word width are dropped by design.
    assign unused_ld_tail = ^bus.ld_data;

    // Each chunk slot takes the left-justified chunk; the last slot may be narrower.
    genvar gi;
    for (gi = 0; gi < NCHUNK; gi++) begin : g_chunk
        localparam int CW = (gi == NCHUNK - 1) ? (WIDTH - gi * LDW) : LDW;
        assign word_next[gi*LDW +: CW] = (accept && (k_reg == KW'(gi)))
                                         ? bus.ld_data[0 +: CW]
                                         : word_reg[gi*LDW +: CW];
    end

    always_ff @(posedge clk) begin
        word_reg <= word_next;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg  <= COLLECT;
            k_reg      <= '0;
            ptr_reg    <= '0;
            badpar_reg <= 1'b0;
            done_reg   <= 1'b0;
        end else begin
            done_reg <= 1'b0;
            case (state_reg)
                COLLECT: begin
                    if (bus.ld_addr_we) begin
                        ptr_reg <= bus.ld_addr;
                        k_reg   <= '0;
                    end else if (bus.run) begin
                        k_reg <= '0;
                    end else if (bus.ld_valid) begin
                        if (last_chunk) begin
                            badpar_reg <= bus.ld_badpar;
                            k_reg      <= '0;
                            state_reg  <= WRITE;
                        end else begin
                            k_reg <= k_reg + KW'(1);
                        end
                    end
                end
                WRITE: begin
                    done_reg  <= 1'b1;
                    state_reg <= COLLECT;
                    // A pointer load arriving during the write lands after it.
                    if (bus.ld_addr_we)
                        ptr_reg <= bus.ld_addr;
                    else if (AUTOINC != 0)
                        ptr_reg <= ptr_next;
                end
            endcase
        end
    end

    // Stored parity bit makes data+parity odd; bad-parity loads flip it.
    assign we      = (state_reg == WRITE) && !reset;
    assign wr_word = {word_reg, ~(^word_reg) ^ badpar_reg};

    always_ff @(posedge clk) begin
        if (we)
            mem[ptr_reg] <= wr_word;
    end

    // Address register then array read; a write at the same edge as the
    // address sample is visible to that read on the following edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            cradr_reg <= '0;
            rd_reg    <= {{WIDTH{1'b0}}, 1'b1};
        end else begin
            cradr_reg <= bus.cradr;
            rd_reg    <= mem[cradr_reg];
        end
    end

    assign perr_now = ~(^rd_reg);

    if (READ_LAT == 2) begin : g_lat2
        logic [0:WIDTH-1] data_reg;
        logic             perr_reg;
        always_ff @(posedge clk) begin
            if (reset) begin
                data_reg <= '0;
                perr_reg <= 1'b0;
            end else begin
                data_reg <= rd_reg[0:WIDTH-1];
                perr_reg <= perr_now;
            end
        end
        assign bus.cram_data = data_reg;
        assign bus.cram_perr = perr_reg;
    end else begin : g_lat1
        assign bus.cram_data = rd_reg[0:WIDTH-1];
        assign bus.cram_perr = perr_now;
    end

    always_ff @(posedge clk) begin
        if (reset)
            sticky_reg <= 1'b0;
        else if (bus.cram_perr)
            sticky_reg <= 1'b1;
        else if (bus.perr_clr)
            sticky_reg <= 1'b0;
    end

    assign bus.perr_sticky = sticky_reg;
endmodule
